// File: rtl/maze_tile_monitor.sv
// Tile monitor: looks up the world-map tile under the icon whenever it moves and
// reports tile flags, goal/wall events and saturating move/wall-hit counters.
module maze_tile_monitor #(
    parameter int MAP_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       loc_x,
    input  logic [7:0]       loc_y,
    input  logic             clear,
    output logic [13:0]      map_addr,
    output logic             map_rd,
    input  logic [1:0]       map_data,
    output logic [1:0]       tile_type,
    output logic             on_wall,
    output logic             at_goal,
    output logic             goal_reached,
    output logic             goal_hit,
    output logic             upd_stb,
    output logic [CNT_W-1:0] move_count,
    output logic [7:0]       wall_hits
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_EVAL
    } state_t;

    localparam logic [1:0]       TILE_WALL = 2'b01;
    localparam logic [1:0]       TILE_GOAL = 2'b10;
    localparam logic [1:0]       LAT_INIT  = 2'(MAP_LATENCY - 1);
    localparam logic [CNT_W-1:0] MOVE_MAX  = '1;
    localparam logic [7:0]       HITS_MAX  = 8'hFF;

    state_t      state;
    state_t      next_state;
    logic [7:0]  cur_x;
    logic [7:0]  cur_y;
    logic        pend;
    logic        init_pend;
    logic [1:0]  lat_cnt;
    logic [1:0]  tile_q;
    logic        loc_moved;
    logic        loc_oor;
    logic        start;
    logic        new_wall;
    logic        new_goal;

    assign loc_moved = (loc_x != cur_x) || (loc_y != cur_y);
    assign loc_oor   = loc_x[7] | loc_y[7];
    assign start     = loc_moved | init_pend | pend;
    assign new_wall  = (tile_q == TILE_WALL) && (tile_type != TILE_WALL);
    assign new_goal  = (tile_q == TILE_GOAL) && (tile_type != TILE_GOAL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Off-map coordinates never touch the ROM; they are evaluated as a wall directly.
    always_comb begin
        next_state = state;
        map_rd     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = loc_oor ? ST_EVAL : ST_RD;
                end
            end
            ST_RD: begin
                map_rd     = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    next_state = ST_EVAL;
                end
            end
            ST_EVAL: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_x     <= 8'd0;
            cur_y     <= 8'd0;
            pend      <= 1'b0;
            init_pend <= 1'b1;
            lat_cnt   <= 2'd0;
            tile_q    <= 2'd0;
            map_addr  <= 14'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_x    <= loc_x;
                        cur_y    <= loc_y;
                        map_addr <= {loc_y[6:0], loc_x[6:0]};
                        pend     <= 1'b0;
                        if (loc_oor) begin
                            tile_q <= TILE_WALL;
                        end
                    end
                end
                ST_RD: begin
                    lat_cnt <= LAT_INIT;
                    if (loc_moved) begin
                        pend <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        tile_q <= map_data;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                    if (loc_moved) begin
                        pend <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    init_pend <= 1'b0;
                    if (loc_moved) begin
                        pend <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The post-reset lookup only refreshes the tile flags; it is not a move.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tile_type    <= 2'd0;
            on_wall      <= 1'b0;
            at_goal      <= 1'b0;
            goal_reached <= 1'b0;
            goal_hit     <= 1'b0;
            upd_stb      <= 1'b0;
            move_count   <= '0;
            wall_hits    <= 8'd0;
        end else begin
            upd_stb  <= 1'b0;
            goal_hit <= 1'b0;
            if (state == ST_EVAL) begin
                tile_type <= tile_q;
                on_wall   <= (tile_q == TILE_WALL);
                at_goal   <= (tile_q == TILE_GOAL);
                upd_stb   <= 1'b1;
                if (!init_pend) begin
                    if (move_count != MOVE_MAX) begin
                        move_count <= move_count + CNT_W'(1);
                    end
                    if (new_wall && (wall_hits != HITS_MAX)) begin
                        wall_hits <= wall_hits + 8'd1;
                    end
                    if (new_goal) begin
                        goal_hit     <= 1'b1;
                        goal_reached <= 1'b1;
                    end
                end
            end
            if (clear) begin
                move_count   <= '0;
                wall_hits    <= 8'd0;
                goal_reached <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maze_tile_monitor.sv
// Randomized self-checking bench for maze_tile_monitor: a behavioural ROM plus a
// transaction-level model of tile flags and counters.
module tb_maze_tile_monitor;

    localparam int ML       = 1;
    localparam int CW       = 8;
    localparam int MOVE_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    loc_x;
    logic [7:0]    loc_y;
    logic          clear;
    logic [13:0]   map_addr;
    logic          map_rd;
    logic [1:0]    map_data;
    logic [1:0]    tile_type;
    logic          on_wall;
    logic          at_goal;
    logic          goal_reached;
    logic          goal_hit;
    logic          upd_stb;
    logic [CW-1:0] move_count;
    logic [7:0]    wall_hits;

    int n_cmp   = 0;
    int n_err   = 0;
    int rd_cnt  = 0;
    int upd_cnt = 0;

    logic [1:0] rom [0:16383];
    logic [1:0] pipe [0:ML-1];

    logic [1:0] m_tile;
    int         m_moves;
    int         m_walls;
    bit         m_goal;
    bit         m_init;
    bit         m_hit;
    logic [7:0] cur_tx;
    logic [7:0] cur_ty;

    maze_tile_monitor #(.MAP_LATENCY(ML), .CNT_W(CW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .loc_x(loc_x),
        .loc_y(loc_y),
        .clear(clear),
        .map_addr(map_addr),
        .map_rd(map_rd),
        .map_data(map_data),
        .tile_type(tile_type),
        .on_wall(on_wall),
        .at_goal(at_goal),
        .goal_reached(goal_reached),
        .goal_hit(goal_hit),
        .upd_stb(upd_stb),
        .move_count(move_count),
        .wall_hits(wall_hits)
    );

    always #5 clk = ~clk;

    // World-map ROM: data for a read appears ML edges after the strobe; junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= map_rd ? rom[map_addr] : 2'($urandom);
        for (int i = 1; i < ML; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign map_data = pipe[ML-1];

    always @(negedge clk) begin
        if (map_rd) rd_cnt <= rd_cnt + 1;
        if (upd_stb) upd_cnt <= upd_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic setTile(input int x, input int y, input logic [1:0] t);
        rom[y * 128 + x] = t;
    endtask

    task automatic modelReset();
        m_tile  = 2'b00;
        m_moves = 0;
        m_walls = 0;
        m_goal  = 1'b0;
        m_init  = 1'b1;
        m_hit   = 1'b0;
    endtask

    task automatic modelEval(input logic [7:0] x, input logic [7:0] y);
        logic [1:0] t;
        t = (x[7] || y[7]) ? 2'b01 : rom[{y[6:0], x[6:0]}];
        m_hit = 1'b0;
        if (!m_init) begin
            if (m_moves < MOVE_MAX) m_moves++;
            if (t == 2'b01 && m_tile != 2'b01 && m_walls < 255) m_walls++;
            if (t == 2'b10 && m_tile != 2'b10) begin
                m_hit  = 1'b1;
                m_goal = 1'b1;
            end
        end
        m_tile = t;
        m_init = 1'b0;
    endtask

    task automatic checkState(input string pfx);
        checkOutput({pfx, "_tile"}, 32'(tile_type), 32'(m_tile));
        checkOutput({pfx, "_on_wall"}, 32'(on_wall), 32'(m_tile == 2'b01));
        checkOutput({pfx, "_at_goal"}, 32'(at_goal), 32'(m_tile == 2'b10));
        checkOutput({pfx, "_moves"}, 32'(move_count), 32'(m_moves));
        checkOutput({pfx, "_walls"}, 32'(wall_hits), 32'(m_walls));
        checkOutput({pfx, "_goal_reached"}, 32'(goal_reached), 32'(m_goal));
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_tile", 32'(tile_type), 0);
        checkOutput("rst_flags", 32'({on_wall, at_goal, goal_reached, goal_hit, upd_stb, map_rd}), 0);
        checkOutput("rst_moves", 32'(move_count), 0);
        checkOutput("rst_walls", 32'(wall_hits), 0);
        checkOutput("rst_addr", 32'(map_addr), 0);
    endtask

    // Loc is already driven; wait for the lookup to complete and check it.
    task automatic finishLookup(input logic [7:0] x, input logic [7:0] y, input bit clr,
                                input int rd0, input int upd0);
        int k;
        int lat;
        bit oor;
        oor = x[7] | y[7];
        lat = oor ? 2 : ML + 3;
        k = 0;
        do begin
            tick();
            k++;
            if (k == 1) checkOutput("rd_at_n1", 32'(map_rd), oor ? 0 : 1);
            clear = (clr && k == lat - 1);
        end while (!upd_stb && k < 20);
        clear = 1'b0;
        checkOutput("latency", k, lat);
        modelEval(x, y);
        if (clr) begin
            m_moves = 0;
            m_walls = 0;
            m_goal  = 1'b0;
        end
        cur_tx = x;
        cur_ty = y;
        checkOutput("rd_count", rd_cnt - rd0, oor ? 0 : 1);
        checkOutput("upd_count", upd_cnt - upd0, 1);
        checkOutput("map_addr", 32'(map_addr), 32'({y[6:0], x[6:0]}));
        checkState("lookup");
        if (!clr) checkOutput("goal_hit", 32'(goal_hit), 32'(m_hit));
        tick();
        checkOutput("upd_pulse", 32'(upd_stb), 0);
        checkOutput("hit_pulse", 32'(goal_hit), 0);
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input bit clr);
        int rd0;
        int upd0;
        rd0   = rd_cnt;
        upd0  = upd_cnt;
        loc_x = x;
        loc_y = y;
        finishLookup(x, y, clr, rd0, upd0);
    endtask

    task automatic idleCheck(input int n);
        int rd0;
        int upd0;
        rd0  = rd_cnt;
        upd0 = upd_cnt;
        repeat (n) tick();
        checkOutput("idle_rd", rd_cnt - rd0, 0);
        checkOutput("idle_upd", upd_cnt - upd0, 0);
        checkState("idle");
    endtask

    task automatic clearPulse();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_moves = 0;
        m_walls = 0;
        m_goal  = 1'b0;
        checkState("clear");
    endtask

    initial begin
        int rd0;
        int upd0;
        int k;
        logic [7:0] rx;
        logic [7:0] ry;

        reset_n = 1'b0;
        clear   = 1'b0;
        loc_x   = 8'd32;
        loc_y   = 8'd32;
        for (int i = 0; i < 16384; i++) rom[i] = 2'($urandom_range(0, 3));
        setTile(32, 32, 2'b00);
        setTile(33, 32, 2'b00);
        setTile(34, 32, 2'b01);
        setTile(35, 32, 2'b00);
        setTile(36, 32, 2'b01);
        setTile(37, 32, 2'b10);
        setTile(40, 40, 2'b00);
        setTile(41, 41, 2'b01);
        modelReset();

        // Power-on lookup of the resting position
        repeat (3) tick();
        checkResetOutputs();
        reset_n = 1'b1;
        rd0  = rd_cnt;
        upd0 = upd_cnt;
        finishLookup(8'd32, 8'd32, 1'b0, rd0, upd0);
        checkOutput("init_addr", 32'(map_addr), 32'h1020);
        idleCheck(5);

        // Single step, then wall entries separated by floor
        applyStimulus(8'd33, 8'd32, 1'b0);
        applyStimulus(8'd34, 8'd32, 1'b0);
        applyStimulus(8'd35, 8'd32, 1'b0);
        applyStimulus(8'd36, 8'd32, 1'b0);
        checkOutput("two_walls", 32'(wall_hits), 2);
        idleCheck(6);

        // Moves during a lookup collapse into one follow-up read at the final loc
        rd0  = rd_cnt;
        upd0 = upd_cnt;
        loc_x = 8'd33; loc_y = 8'd32;
        tick();
        loc_x = 8'd36;
        tick();
        loc_x = 8'd40; loc_y = 8'd40;
        k = 0;
        while ((upd_cnt - upd0) < 2 && k < 30) begin
            tick();
            k++;
        end
        repeat (3) tick();
        modelEval(8'd33, 8'd32);
        modelEval(8'd40, 8'd40);
        cur_tx = 8'd40; cur_ty = 8'd40;
        checkOutput("coal_rd", rd_cnt - rd0, 2);
        checkOutput("coal_upd", upd_cnt - upd0, 2);
        checkOutput("coal_addr", 32'(map_addr), 32'({7'd40, 7'd40}));
        checkState("coal");

        // Goal entry, then clear leaves the tile flags alone
        applyStimulus(8'd37, 8'd32, 1'b0);
        clearPulse();

        // Off-map position, then reset in the middle of a ROM wait
        applyStimulus(8'd200, 8'd32, 1'b0);
        rd0 = rd_cnt;
        loc_x = 8'd41; loc_y = 8'd41;
        tick();
        tick();
        checkOutput("abort_rd_issued", rd_cnt - rd0, 1);
        reset_n = 1'b0;
        #1;
        checkResetOutputs();
        modelReset();
        tick();
        tick();
        reset_n = 1'b1;
        rd0  = rd_cnt;
        upd0 = upd_cnt;
        finishLookup(8'd41, 8'd41, 1'b0, rd0, upd0);

        // Clear landing on the evaluation edge
        applyStimulus(8'd33, 8'd32, 1'b1);

        // Drive both counters into saturation
        clearPulse();
        for (int i = 0; i < 260; i++) begin
            applyStimulus(8'd34, 8'd32, 1'b0);
            applyStimulus(8'd35, 8'd32, 1'b0);
        end
        checkOutput("walls_sat", 32'(wall_hits), 255);
        checkOutput("moves_sat", 32'(move_count), MOVE_MAX);

        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                rx = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
                ry = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
                if (rx == cur_tx && ry == cur_ty) rx = rx ^ 8'h01;
                applyStimulus(rx, ry, $urandom_range(0, 9) == 0);
            end else if (r < 85) begin
                idleCheck(3 + $urandom_range(0, 3));
            end else begin
                clearPulse();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
